tdm_demux_10ch: RTL and testbench

Time-division demultiplexer: the receive-side counterpart of the team's 10-input selector. It accepts a serial stream of 10-slot frames on one input and distributes each slot to its own output lane. The slot counter is sequential and wraps strictly at 10. It presents one registered parallel word per complete frame, plus a per-slot one-hot write strobe. It sits after a serialised link and feeds 10 independent downstream consumers.

---
 rtl/tdm_demux_10ch.sv | 105 ++++++++++
 tb/tb_tdm_demux_10ch.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_10ch.sv
// tdm_demux_10ch: receive-side time-division demultiplexer.
// A serial stream of NCH-slot frames is collected into a shadow register and
// presented as one registered parallel word per completed frame. Each accepted
// sample also gets a registered one-hot strobe and a copy on lane_data.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a valid sample flagged with frame_start
// RECV  | collecting slots 1..NCH-1 of the current frame
module tdm_demux_10ch #(
    parameter int WIDTH = 1,
    parameter int NCH   = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 frame_start,
    output logic [3:0]           slot,
    output logic [NCH-1:0]       strobe,
    output logic [WIDTH-1:0]     lane_data,
    output logic [NCH*WIDTH-1:0] y,
    output logic                 y_valid,
    output logic                 frame_err,
    output logic                 busy
);

    typedef enum logic {IDLE, RECV} state_t;

    localparam logic [3:0]     LAST_SLOT = 4'(NCH - 1);
    localparam logic [NCH-1:0] ONE_HOT0  = NCH'(1);

    state_t                 state, state_n;
    logic [3:0]             slot_n;
    logic [NCH*WIDTH-1:0]   shadow, shadow_n;
    logic [NCH-1:0]         strobe_n;
    logic [WIDTH-1:0]       lane_n;
    logic [NCH*WIDTH-1:0]   y_n;
    logic                   y_valid_n;
    logic                   frame_err_n;

    // State and output registers; reset drops any partial frame silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            slot      <= '0;
            shadow    <= '0;
            strobe    <= '0;
            lane_data <= '0;
            y         <= '0;
            y_valid   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            slot      <= slot_n;
            shadow    <= shadow_n;
            strobe    <= strobe_n;
            lane_data <= lane_n;
            y         <= y_n;
            y_valid   <= y_valid_n;
            frame_err <= frame_err_n;
        end
    end

    // Next-state logic. frame_start on a valid sample always restarts at
    // slot 0, so it outranks completion when both land on slot NCH-1.
    always_comb begin
        state_n     = state;
        slot_n      = slot;
        shadow_n    = shadow;
        strobe_n    = '0;
        lane_n      = lane_data;
        y_n         = y;
        y_valid_n   = 1'b0;
        frame_err_n = 1'b0;
        if (din_valid) begin
            if (frame_start) begin
                frame_err_n             = (state == RECV) && (slot != 4'd0);
                shadow_n                = '0;
                shadow_n[WIDTH-1:0]     = din;
                slot_n                  = 4'd1;
                state_n                 = RECV;
                strobe_n                = ONE_HOT0;
                lane_n                  = din;
            end else if (state == RECV) begin
                strobe_n = ONE_HOT0 << slot;
                lane_n   = din;
                shadow_n[int'(slot)*WIDTH +: WIDTH] = din;
                if (slot == LAST_SLOT) begin
                    y_n                            = shadow;
                    y_n[(NCH-1)*WIDTH +: WIDTH]    = din;
                    y_valid_n                      = 1'b1;
                    slot_n                         = 4'd0;
                    state_n                        = IDLE;
                end else begin
                    slot_n = slot + 4'd1;
                end
            end
        end
    end

    // busy mirrors the RECV state directly.
    assign busy = (state == RECV);

endmodule

// File: tb/tb_tdm_demux_10ch.sv
// Directed testbench for tdm_demux_10ch with WIDTH=1, NCH=10.
module tb_tdm_demux_10ch;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:0] din;
    logic       din_valid;
    logic       frame_start;
    logic [3:0] slot;
    logic [9:0] strobe;
    logic [0:0] lane_data;
    logic [9:0] y;
    logic       y_valid;
    logic       frame_err;
    logic       busy;

    int passed = 0;
    int total  = 0;

    tdm_demux_10ch #(.WIDTH(1), .NCH(10)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .frame_start(frame_start), .slot(slot), .strobe(strobe),
        .lane_data(lane_data), .y(y), .y_valid(y_valid),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and sample 1 time unit after the edge.
    task automatic send(input logic v, input logic fs, input logic d);
        din_valid   = v;
        frame_start = fs;
        din         = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; frame_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({slot, strobe, lane_data, y, y_valid, frame_err, busy} !== 28'd0)
            $display("FAIL reset_outputs: got slot=%0d strobe=%b lane=%b y=%b yv=%b err=%b busy=%b, need all 0",
                     slot, strobe, lane_data, y, y_valid, frame_err, busy);
        else passed++;
        rst = 1'b0;
        send(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_single_frame;
        logic [9:0] bits = 10'b1101001101;
        logic [9:0] exp_s;
        for (int i = 0; i < 10; i++) begin
            send(1'b1, i == 0, bits[i]);
            exp_s = 10'd1 << i;
            total++;
            if (strobe !== exp_s || lane_data !== bits[i])
                $display("FAIL single_strobe[%0d]: got strobe=%b lane=%b, need strobe=%b lane=%b",
                         i, strobe, lane_data, exp_s, bits[i]);
            else passed++;
            total++;
            if (slot !== 4'((i + 1) % 10) || busy !== (i < 9) || y_valid !== (i == 9))
                $display("FAIL single_ctrl[%0d]: got slot=%0d busy=%b yv=%b, need slot=%0d busy=%b yv=%b",
                         i, slot, busy, y_valid, (i + 1) % 10, i < 9, i == 9);
            else passed++;
        end
        total++;
        if (y !== 10'b1101001101)
            $display("FAIL single_y: got %b, need 1101001101", y);
        else passed++;
        send(1'b0, 1'b0, 1'b0);
        total++;
        if (y_valid !== 1'b0 || strobe !== 10'd0 || y !== 10'b1101001101)
            $display("FAIL single_after: got yv=%b strobe=%b y=%b, need 0 0 1101001101", y_valid, strobe, y);
        else passed++;
    endtask

    task automatic test_gaps;
        logic [9:0] bits = 10'b1101001101;
        int yv_count = 0;
        for (int i = 0; i < 10; i++) begin
            send(1'b1, i == 0, bits[i]);
            if (y_valid) yv_count++;
            if (i == 2 || i == 7) begin
                for (int g = 0; g < 3; g++) begin
                    send(1'b0, 1'b0, ~bits[i]);
                    total++;
                    if (strobe !== 10'd0 || busy !== 1'b1 || y_valid !== 1'b0 || slot !== 4'(i + 1))
                        $display("FAIL gap_hold[%0d.%0d]: got strobe=%b busy=%b yv=%b slot=%0d, need 0 1 0 %0d",
                                 i, g, strobe, busy, y_valid, slot, i + 1);
                    else passed++;
                end
            end
        end
        total++;
        if (y !== 10'b1101001101 || y_valid !== 1'b1 || yv_count !== 1 || busy !== 1'b0)
            $display("FAIL gap_frame: got y=%b yv=%b pulses=%0d busy=%b, need 1101001101 1 1 0",
                     y, y_valid, yv_count, busy);
        else passed++;
        send(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_abort;
        send(1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 5; i++) send(1'b1, 1'b0, 1'b1);
        total++;
        if (slot !== 4'd5)
            $display("FAIL abort_pre_slot: got %0d, need 5", slot);
        else passed++;
        send(1'b1, 1'b1, 1'b0);
        total++;
        if (frame_err !== 1'b1 || y_valid !== 1'b0 || y !== 10'b1101001101 ||
            slot !== 4'd1 || strobe !== 10'd1 || busy !== 1'b1)
            $display("FAIL abort_pulse: got err=%b yv=%b y=%b slot=%0d strobe=%b busy=%b, need 1 0 1101001101 1 0000000001 1",
                     frame_err, y_valid, y, slot, strobe, busy);
        else passed++;
        for (int i = 1; i < 10; i++) begin
            send(1'b1, 1'b0, 1'b1);
            total++;
            if (frame_err !== 1'b0 || y_valid !== (i == 9))
                $display("FAIL abort_refill[%0d]: got err=%b yv=%b, need 0 %b", i, frame_err, y_valid, i == 9);
            else passed++;
        end
        total++;
        if (y !== 10'b1111111110)
            $display("FAIL abort_y: got %b, need 1111111110", y);
        else passed++;
        // frame_start on the last-slot sample restarts rather than completes
        send(1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 9; i++) send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b1);
        total++;
        if (frame_err !== 1'b1 || y_valid !== 1'b0 || slot !== 4'd1 || y !== 10'b1111111110)
            $display("FAIL abort_last: got err=%b yv=%b slot=%0d y=%b, need 1 0 1 1111111110",
                     frame_err, y_valid, slot, y);
        else passed++;
        for (int i = 1; i < 10; i++) send(1'b1, 1'b0, 1'b0);
        total++;
        if (y !== 10'b0000000001 || y_valid !== 1'b1)
            $display("FAIL abort_last_y: got y=%b yv=%b, need 0000000001 1", y, y_valid);
        else passed++;
        send(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        int first_pulse = -1;
        int second_pulse = -1;
        int max_slot = 0;
        for (int c = 0; c < 20; c++) begin
            if (c < 10) send(1'b1, c == 0, c[0]);
            else        send(1'b1, c == 10, c == 10);
            if (y_valid) begin
                if (first_pulse < 0) first_pulse = c;
                else                 second_pulse = c;
            end
            if (int'(slot) > max_slot) max_slot = int'(slot);
            if (c == 9) begin
                total++;
                if (y !== 10'b1010101010)
                    $display("FAIL b2b_y0: got %b, need 1010101010", y);
                else passed++;
            end
            if (c == 10) begin
                total++;
                if (slot !== 4'd1 || busy !== 1'b1 || frame_err !== 1'b0)
                    $display("FAIL b2b_restart: got slot=%0d busy=%b err=%b, need 1 1 0", slot, busy, frame_err);
                else passed++;
            end
        end
        total++;
        if (first_pulse !== 9 || second_pulse !== 19 || max_slot > 9)
            $display("FAIL b2b_pulses: got first=%0d second=%0d max_slot=%0d, need 9 19 <=9",
                     first_pulse, second_pulse, max_slot);
        else passed++;
        total++;
        if (y !== 10'b0000000001)
            $display("FAIL b2b_y1: got %b, need 0000000001", y);
        else passed++;
        send(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_idle_drop;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 1'b0, i[0]);
            total++;
            if (strobe !== 10'd0 || slot !== 4'd0 || busy !== 1'b0 || y !== 10'b0000000001 || y_valid !== 1'b0)
                $display("FAIL idle_drop[%0d]: got strobe=%b slot=%0d busy=%b y=%b yv=%b, need 0 0 0 0000000001 0",
                         i, strobe, slot, busy, y, y_valid);
            else passed++;
        end
        // frame_start with din_valid low is ignored
        send(1'b0, 1'b1, 1'b1);
        total++;
        if (busy !== 1'b0 || strobe !== 10'd0 || slot !== 4'd0)
            $display("FAIL idle_fs_novalid: got busy=%b strobe=%b slot=%0d, need 0 0 0", busy, strobe, slot);
        else passed++;
    endtask

    task automatic test_reset_midframe;
        send(1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 6; i++) send(1'b1, 1'b0, 1'b1);
        total++;
        if (slot !== 4'd6 || busy !== 1'b1)
            $display("FAIL mid_pre: got slot=%0d busy=%b, need 6 1", slot, busy);
        else passed++;
        din_valid = 1'b0;
        frame_start = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if ({slot, strobe, lane_data, y, y_valid, frame_err, busy} !== 28'd0)
            $display("FAIL mid_reset_async: got slot=%0d strobe=%b lane=%b y=%b yv=%b err=%b busy=%b, need all 0",
                     slot, strobe, lane_data, y, y_valid, frame_err, busy);
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(1'b0, 1'b0, 1'b0);
        total++;
        if (frame_err !== 1'b0 || y_valid !== 1'b0)
            $display("FAIL mid_no_pulse: got err=%b yv=%b, need 0 0", frame_err, y_valid);
        else passed++;
        for (int i = 0; i < 10; i++) send(1'b1, i == 0, 1'b1);
        total++;
        if (y !== 10'h3FF || y_valid !== 1'b1 || slot !== 4'd0 || frame_err !== 1'b0)
            $display("FAIL mid_refill: got y=%b yv=%b slot=%0d err=%b, need 1111111111 1 0 0",
                     y, y_valid, slot, frame_err);
        else passed++;
        send(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_gaps;
        test_abort;
        test_back_to_back;
        test_idle_drop;
        test_reset_midframe;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
